// File: rtl/jump_target_encoder.sv
`timescale 1ns/1ps
// Two-stage valid/ready encoder from a byte-address control-flow destination to the
// MIPS J-type instr_index or I-type branch offset, with misalignment/range flags.
module jump_target_encoder (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic        in_mode,
   input  logic [31:0] in_pc,
   input  logic [31:0] in_target,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [25:0] out_field,
   output logic        out_misaligned,
   output logic        out_out_of_range,
   output logic [7:0]  err_count
);

   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   // dq is diff >>> 2, so dq[29:15] are diff[31:17]; they must be a pure sign extension.
   function automatic logic branch_oor(input logic signed [29:0] dq);
      return !((dq[29:15] == 15'h0000) || (dq[29:15] == 15'h7FFF));
   endfunction

   logic               s1_free;
   logic               s2_free;
   logic [29:0]        pc4w_p0;
   logic               borrow_p0;
   logic signed [29:0] dq_p0;

   logic               vld_p1;
   logic               mode_p1;
   logic               mis_p1;
   logic [3:0]         pc4_hi_p1;
   logic [3:0]         tgt_hi_p1;
   logic [25:0]        tgt_idx_p1;
   logic signed [29:0] dq_p1;
   logic [25:0]        field_p1;
   logic               oor_p1;

   assign s2_free  = !out_valid || out_ready;
   assign s1_free  = !vld_p1 || s2_free;
   assign in_ready = s1_free;

   // Word-granular pc+4 and (target - pc4) >>> 2; the borrow carries the byte offsets.
   assign pc4w_p0   = in_pc[31:2] + 30'd1;
   assign borrow_p0 = (in_target[1:0] < in_pc[1:0]);
   assign dq_p0     = signed'(in_target[31:2] - pc4w_p0 - {29'd0, borrow_p0});

   // ---- S1: request register ----
   always_ff @(posedge clk) begin
      if (reset) begin
         vld_p1 <= 1'b0;
      end else if (s1_free) begin
         vld_p1 <= in_valid;
      end
   end

   always_ff @(posedge clk) begin
      if (in_valid && s1_free) begin
         mode_p1    <= in_mode;
         mis_p1     <= |{in_pc[1:0], in_target[1:0]};
         pc4_hi_p1  <= pc4w_p0[29:26];
         tgt_hi_p1  <= in_target[31:28];
         tgt_idx_p1 <= in_target[27:2];
         dq_p1      <= dq_p0;
      end
   end

   always_comb begin
      field_p1 = tgt_idx_p1;
      oor_p1   = (tgt_hi_p1 != pc4_hi_p1);
      if (mode_p1) begin
         field_p1 = {10'd0, dq_p1[15:0]};
         oor_p1   = branch_oor(dq_p1);
      end
   end

   // ---- S2: output register ----
   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid        <= 1'b0;
         out_field        <= 26'd0;
         out_misaligned   <= 1'b0;
         out_out_of_range <= 1'b0;
      end else if (s2_free) begin
         out_valid <= vld_p1;
         if (vld_p1) begin
            out_field        <= field_p1;
            out_misaligned   <= mis_p1;
            out_out_of_range <= oor_p1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         err_count <= 8'd0;
      end else if (out_valid && out_ready && (out_misaligned || out_out_of_range)) begin
         err_count <= sat_inc(err_count);
      end
   end

endmodule

// File: tb/tb_jump_target_encoder.sv
`timescale 1ns/1ps
// Directed and randomised bench for jump_target_encoder with a queue-based reference model.
module tb_jump_target_encoder;

   logic        clk;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic        in_mode;
   logic [31:0] in_pc;
   logic [31:0] in_target;
   logic        out_valid;
   logic        out_ready;
   logic [25:0] out_field;
   logic        out_misaligned;
   logic        out_out_of_range;
   logic [7:0]  err_count;

   jump_target_encoder dut (
      .clk              (clk),
      .reset            (reset),
      .in_valid         (in_valid),
      .in_ready         (in_ready),
      .in_mode          (in_mode),
      .in_pc            (in_pc),
      .in_target        (in_target),
      .out_valid        (out_valid),
      .out_ready        (out_ready),
      .out_field        (out_field),
      .out_misaligned   (out_misaligned),
      .out_out_of_range (out_out_of_range),
      .err_count        (err_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          total = 0;
   int          bad = 0;
   int          exp_err = 0;
   logic        ir_at2;
   int          acc_at2;
   logic [27:0] packed_out;
   logic        rq_mode [0:1199];
   logic [31:0] rq_pc   [0:1199];
   logic [31:0] rq_tgt  [0:1199];
   logic [27:0] exp_q [$];

   assign packed_out = {out_field, out_misaligned, out_out_of_range};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [27:0] model(input logic m, input logic [31:0] pc, input logic [31:0] tg);
      logic [31:0] pc4;
      logic [31:0] diff;
      logic [25:0] f;
      logic        mis;
      logic        oor;
      pc4  = pc + 32'd4;
      diff = tg - pc4;
      mis  = (pc[1:0] != 2'b00) || (tg[1:0] != 2'b00);
      if (!m) begin
         f   = tg[27:2];
         oor = (tg[31:28] != pc4[31:28]);
      end else begin
         f   = {10'd0, diff[17:2]};
         oor = ($signed(diff) < -32'sd131072) || ($signed(diff) > 32'sd131071);
      end
      return {f, mis, oor};
   endfunction

   task automatic dir_req(input string tag, input logic m, input logic [31:0] pc, input logic [31:0] tg,
                          input logic [25:0] f, input logic mis, input logic oor, input logic [7:0] errc);
      @(posedge clk); #1;
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_mode   = m;
      in_pc     = pc;
      in_target = tg;
      @(posedge clk); #1;
      in_valid  = 1'b0;
      in_pc     = 32'hDEAD_BEEF;
      in_target = 32'h1234_5677;
      chk({tag, "_lat"}, 32'(out_valid), 32'd0);
      @(posedge clk); #1;
      chk({tag, "_valid"}, 32'(out_valid), 32'd1);
      chk({tag, "_field"}, 32'(out_field), 32'(f));
      chk({tag, "_mis"}, 32'(out_misaligned), 32'(mis));
      chk({tag, "_oor"}, 32'(out_out_of_range), 32'(oor));
      @(posedge clk); #1;
      chk({tag, "_err"}, 32'(err_count), 32'(errc));
      chk({tag, "_drain"}, 32'(out_valid), 32'd0);
   endtask

   task automatic run_traffic(input int n, input bit rnd, input int hold);
      int          sent;
      int          got;
      int          cyc;
      bit          held_v;
      logic [27:0] held;
      logic [27:0] e;
      sent = 0; got = 0; cyc = 0; held_v = 0; held = '0;
      while ((sent < n || got < n) && cyc < n * 20 + 100) begin
         @(posedge clk); #1;
         if (held_v) chk("hold", 32'({out_valid, packed_out}), 32'({1'b1, held}));
         if (sent < n && (!rnd || $urandom_range(0, 3) != 0)) begin
            in_valid  = 1'b1;
            in_mode   = rq_mode[sent];
            in_pc     = rq_pc[sent];
            in_target = rq_tgt[sent];
         end else begin
            in_valid  = 1'b0;
            in_mode   = 1'($urandom_range(0, 1));
            in_pc     = $urandom;
            in_target = $urandom;
         end
         out_ready = (cyc < hold) ? 1'b0 : (rnd ? ($urandom_range(0, 2) != 0) : 1'b1);
         #2;
         if (cyc == 2) begin
            ir_at2  = in_ready;
            acc_at2 = sent;
         end
         held_v = out_valid && !out_ready;
         held   = packed_out;
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_out", 32'(out_valid), 32'd0);
            end else begin
               e = exp_q.pop_front();
               chk("result", 32'(packed_out), 32'(e));
               if ((e[1] || e[0]) && exp_err < 255) exp_err++;
               got++;
            end
         end
         if (in_valid && in_ready) begin
            exp_q.push_back(model(in_mode, in_pc, in_target));
            sent++;
         end
         cyc++;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      if (sent < n || got < n) chk("timeout_results", 32'(got), 32'(n));
   endtask

   initial begin
      #5000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      in_mode = 1'b0; in_pc = 32'd0; in_target = 32'd0;
      @(posedge clk); @(posedge clk); #1;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_err", 32'(err_count), 32'd0);
      chk("rst_field", 32'(out_field), 32'd0);
      chk("rst_flags", 32'({out_misaligned, out_out_of_range}), 32'd0);
      reset = 1'b0;

      dir_req("jump",      1'b0, 32'h0040_0000, 32'h0040_0020, 26'h010_0008, 1'b0, 1'b0, 8'd0);
      dir_req("br_back",   1'b1, 32'h0040_0010, 32'h0040_0000, 26'h000_FFFB, 1'b0, 1'b0, 8'd0);
      dir_req("br_max",    1'b1, 32'h0000_0000, 32'h0002_0000, 26'h000_7FFF, 1'b0, 1'b0, 8'd0);
      dir_req("br_over",   1'b1, 32'h0000_0000, 32'h0002_0004, 26'h000_8000, 1'b0, 1'b1, 8'd1);
      dir_req("br_mis",    1'b1, 32'h0000_0000, 32'h0000_0002, 26'h000_FFFF, 1'b1, 1'b0, 8'd2);
      dir_req("j_region",  1'b0, 32'h0FFF_FFFC, 32'h1000_0000, 26'h000_0000, 1'b0, 1'b0, 8'd2);
      dir_req("j_outside", 1'b0, 32'h0FFF_FFF8, 32'h1000_0000, 26'h000_0000, 1'b0, 1'b1, 8'd3);
      dir_req("br_wrap",   1'b1, 32'hFFFF_FFFC, 32'h0000_0010, 26'h000_0004, 1'b0, 1'b0, 8'd3);

      // fill both stages, then reset with a request still presented
      @(posedge clk); #1;
      out_ready = 1'b0; in_valid = 1'b1; in_mode = 1'b0;
      in_pc = 32'h0040_0000; in_target = 32'h0040_0040;
      @(posedge clk); #1;
      in_target = 32'h0040_0080;
      @(posedge clk); #1;
      chk("full_out_valid", 32'(out_valid), 32'd1);
      chk("full_in_ready", 32'(in_ready), 32'd0);
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
      chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
      chk("mid_rst_err", 32'(err_count), 32'd0);
      chk("mid_rst_field", 32'(out_field), 32'd0);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         chk("post_rst_quiet", 32'(out_valid), 32'd0);
      end
      exp_err = 0;

      for (int i = 0; i < 4; i++) begin
         rq_mode[i] = 1'b0;
         rq_pc[i]   = 32'h0040_0000 + 32'(4 * i);
         rq_tgt[i]  = 32'h0040_0100 + 32'(16 * i);
      end
      run_traffic(4, 1'b0, 3);
      chk("bp_in_ready_low", 32'(ir_at2), 32'd0);
      chk("bp_accepts", 32'(acc_at2), 32'd2);

      for (int i = 0; i < 1000; i++) begin
         int          off;
         logic [31:0] pc;
         logic [31:0] tg;
         pc = $urandom;
         if ($urandom_range(0, 7) != 0) pc[1:0] = 2'b00;
         if ($urandom_range(0, 9) == 0) pc = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
         off = int'($urandom_range(0, 32'h7FFFF)) - 32'h40000;
         case ($urandom_range(0, 3))
            0:       tg = $urandom;
            1:       tg = pc + 32'd4 + 32'(off);
            2:       tg = {(pc[31:28] + 4'(pc[27:2] == 26'h3FF_FFFF)) ^ 4'($urandom_range(0, 1)), 28'($urandom)};
            default: tg = pc + 32'd4 + 32'(off / 8);
         endcase
         if ($urandom_range(0, 7) != 0) tg[1:0] = 2'b00;
         rq_mode[i] = 1'($urandom_range(0, 1));
         rq_pc[i]   = pc;
         rq_tgt[i]  = tg;
      end
      run_traffic(1000, 1'b1, 0);
      @(posedge clk); #1;
      chk("rand_err_count", 32'(err_count), 32'(exp_err));

      for (int i = 0; i < 300; i++) begin
         rq_mode[i] = 1'b1;
         rq_pc[i]   = 32'h0000_0000;
         rq_tgt[i]  = 32'h0000_0002;
      end
      run_traffic(300, 1'b0, 0);
      @(posedge clk); #1;
      chk("err_saturated", 32'(err_count), 32'd255);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/jump_target_encoder.md
# jump_target_encoder

Pipelined encoder that converts a byte-address control-flow destination into the instruction immediate field of the MIPS processor: the 26-bit J-type `instr_index` or the 16-bit I-type branch offset. It is the inverse of the datapath's target-expansion path (index << 2, offset sign-extend << 2). It sits between the instruction-memory loader/patcher and instruction memory, and flags destinations that cannot be encoded. It is a two-stage valid/ready pipeline with one transfer per cycle.

## Interface
- No parameters; all widths are fixed by the MIPS ISA.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  request valid.
- `in_ready`  out  1  encoder can accept a request this cycle.
- `in_mode`  in  1  0 = jump (J-type), 1 = branch (I-type).
- `in_pc`  in  32  byte address of the jump/branch instruction.
- `in_target`  in  32  byte address of the destination.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer accepts the result.
- `out_field`  out  26  encoded immediate; branch mode = {10'b0, offset[15:0]}.
- `out_misaligned`  out  1  `in_pc[1:0]` or `in_target[1:0]` is non-zero.
- `out_out_of_range`  out  1  destination is not reachable by the encoding.
- `err_count`  out  8  saturating count of delivered results with either flag set.

## Operation
- Stage 1 (S1) registers the request and computes:
  - pc4 = in_pc + 4 (mod 2^32).
  - diff = in_target − pc4 (mod 2^32).
- Stage 2 (S2, the output register) computes the encoding.
- Jump mode:
  - field = target[27:2].
  - out_of_range = (target[31:28] != pc4[31:28]).
- Branch mode:
  - offset = diff >>> 2 (arithmetic shift).
  - field = {10'b0, offset[15:0]}.
  - out_of_range = diff[31:17] not all equal, i.e. diff lies outside −131072..+131068.
- Field and flags are always produced; an error does not suppress the result.
- Both flags may be set at the same time.
- Handshakes:
  - s2_free = !out_valid || out_ready.
  - s1_free = !s1_valid || s2_free.
  - in_ready = s1_free.
  - A request transfers when in_valid && in_ready; a result transfers when out_valid && out_ready.
- S2 loads from S1 when s1_valid && s2_free. S2 clears (out_valid → 0) when it drains and S1 is empty.
- Outputs `out_field`/flags hold stable while out_valid && !out_ready. in_* inputs are sampled only on an accepting cycle.
- Results leave in request order, with no loss and no duplication.
- err_count increments by 1 on each result transfer with (out_misaligned || out_out_of_range). It saturates at 255.

## Timing
- Latency: a request accepted at edge N gives out_valid = 1 after edge N+1, provided there is no backpressure.
- Throughput: 1 result per cycle while out_ready = 1.
- in_ready is combinational from out_ready (s1_free path). There is no combinational path from in_valid to out_valid.
- Reset (synchronous, dominates all other inputs) has the following effect at the next edge:
  - s1_valid = 0, out_valid = 0, err_count = 0.
  - out_field = 0, out_misaligned = 0, out_out_of_range = 0.
  - in_ready = 1 after the edge.
- Reset in mid-operation discards both stages. No result issued before the reset re-appears after it.
- Full: S1 and S2 both valid with out_ready = 0 gives in_ready = 0. A simultaneous drain and accept in the same cycle is legal and loses nothing.
- Address wrap: pc4 and diff wrap modulo 2^32 with no error from the wrap itself. For example, pc = 0xFFFFFFFC gives pc4 = 0x00000000.

## Test plan
- Jump, pc = 0x00400000, target = 0x00400020 → field = 0x0100008, flags 0, out_valid two edges after acceptance.
- Branch backward, pc = 0x00400010, target = 0x00400000 → diff = −0x14, field = 0x000FFFB, flags 0.
- Branch range boundary, pc = 0:
  - target = 0x00020000 → field = 0x0007FFF, in range.
  - target = 0x00020004 → out_of_range = 1, err_count 0 → 1.
  - target = 0x00000002 → misaligned = 1.
- Jump region boundary:
  - pc = 0x0FFFFFFC, target = 0x10000000 → in range, field = 0x0000000.
  - pc = 0x0FFFFFF8, same target → out_of_range = 1.
- Backpressure: 4 back-to-back requests with out_ready held 0 for 3 cycles → in_ready drops after 2 accepts. After release, all 4 results arrive in order with held-stable fields. Randomised ready/valid runs for 1000 requests match a reference model.
- Reset mid-flow (both stages full, err_count = 3) → after the reset edge: out_valid = 0, in_ready = 1, err_count = 0. 300 errored results then saturate err_count at 255.
